// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl -- fetch-side sequencing controller for the 5-stage RV32I pipeline.
//
// Drives the PC enable, the IF/ID enable and the IF/ID and ID/EX flushes in response
// to three events: an EX-stage redirect (pc_sel_EX), a load-use hazard, and an
// external halt request.
//
// Events in RUN are taken in priority order:
//   1. redirect
//   2. load-use
//   3. halt
//
// After a redirect the FSM can hold IF/ID flushed for REDIRECT_BUBBLES extra cycles
// (state REDIR). A halt request that arrives during REDIR waits until RUN.
//
// Parameters
//   REDIRECT_BUBBLES  extra cycles IF/ID stays flushed after a redirect (0..7)
//   CNT_W             performance counter width
//
// Ports
//   clk, reset                 clock; synchronous active-high reset
//   rs1_ID, rs2_ID             source fields of the instruction in ID
//   use_rs1_ID, use_rs2_ID     the ID instruction actually reads rs1 / rs2
//   rd_EX, mem_read_EX         destination register of EX, and whether EX is a load
//   pc_sel_EX                  taken branch/jump resolved in EX
//   halt_req                   level request to freeze fetch
//   pc_en, ifid_en             PC and IF/ID load enables
//   ifid_flush                 IF/ID loads a NOP; wins over ifid_en
//   idex_flush                 ID/EX loads a bubble
//   halted                     registered; high while in HALT
//   state_o                    current state (RUN=0, REDIR=1, HALT=2)
//   cycle_cnt, stall_cnt, flush_cnt
//                              performance counters
//
// Configuration macro: HAZARD_PERF_EN
//   When defined, the three counters are implemented.
//   Otherwise they are tied to 0.
module pipe_hazard_ctrl #(
  parameter int REDIRECT_BUBBLES = 0,
  parameter int CNT_W            = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             use_rs1_ID,
  input  logic             use_rs2_ID,
  input  logic [4:0]       rd_EX,
  input  logic             mem_read_EX,
  input  logic             pc_sel_EX,
  input  logic             halt_req,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN = 2'd0, REDIR = 2'd1, HALT = 2'd2} state_t;

  localparam logic [2:0] BUB_RELOAD = 3'(REDIRECT_BUBBLES);

  state_t     state, state_nxt;
  logic [2:0] bub_cnt, bub_nxt;
  logic       load_use;

  // x0 never carries a hazard, because it is hard-wired to zero.
  assign load_use = mem_read_EX && (rd_EX != 5'd0) &&
                    ((use_rs1_ID && (rs1_ID == rd_EX)) ||
                     (use_rs2_ID && (rs2_ID == rd_EX)));

  always_comb begin
    state_nxt  = state;
    bub_nxt    = bub_cnt;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;

    if (reset) begin
      // Keep the pipeline front end squashed while reset is held.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_nxt  = RUN;
      bub_nxt    = 3'd0;
    end else begin
      unique case (state)
        RUN: begin
          if (pc_sel_EX) begin
            // The ID instruction is squashed, so any load-use hazard is moot.
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            if (REDIRECT_BUBBLES > 0) begin
              state_nxt = REDIR;
              bub_nxt   = BUB_RELOAD;
            end
          end else if (load_use) begin
            // A one-cycle stall is enough, because the load then moves to MEM.
            idex_flush = 1'b1;
          end else if (halt_req) begin
            idex_flush = 1'b1;
            state_nxt  = HALT;
          end else begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
          end
        end

        REDIR: begin
          // halt_req is intentionally ignored here; RUN picks it up,
          // because the request is level-sensitive.
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
          if (pc_sel_EX) begin
            bub_nxt = BUB_RELOAD;
          end else begin
            bub_nxt = bub_cnt - 3'd1;
            if (bub_cnt == 3'd1) state_nxt = RUN;
          end
        end

        HALT: begin
          if (halt_req) begin
            idex_flush = 1'b1;
          end else begin
            // Resume immediately from the held PC; IF/ID still holds a valid instruction.
            pc_en     = 1'b1;
            ifid_en   = 1'b1;
            state_nxt = RUN;
          end
        end

        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      bub_cnt <= 3'd0;
      halted  <= 1'b0;
    end else begin
      state   <= state_nxt;
      bub_cnt <= bub_nxt;
      halted  <= (state_nxt == HALT);
    end
  end

  assign state_o = state;

`ifdef HAZARD_PERF_EN
  logic             stall_evt, flush_evt;
  logic [CNT_W-1:0] cyc_q, stall_q, flush_q;

  // A stall counts only when it wins arbitration in RUN.
  // A redirect counts whenever it is not ignored in HALT.
  assign stall_evt = (state == RUN) && !pc_sel_EX && load_use;
  assign flush_evt = pc_sel_EX && (state != HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      cyc_q <= cyc_q + 1'b1;
      if (stall_evt) stall_q <= stall_q + 1'b1;
      if (flush_evt) flush_q <= flush_q + 1'b1;
    end
  end

  assign cycle_cnt = cyc_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign cycle_cnt = '0;
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
